// File: rtl/stream_mux_rr.sv
// Purpose: N-to-1 stream multiplexer with fixed-priority, round-robin or manual channel selection.
// Latency: 1 cycle from an input transfer to out_valid; the output register sustains 1 word/cycle.
// Backpressure: while out_valid=1 and out_ready=0 all in_ready bits are 0 and the held word is frozen.
//
// Ports:
//   clk, rst          clock and synchronous active-high reset
//   mode              0/3 fixed priority (lowest index), 1 round-robin, 2 manual (sel)
//   sel               channel index used in manual mode; values >= N never grant
//   in_data/in_valid  channel k occupies in_data[k*W +: W]
//   in_ready          one-hot (or zero) ready back to the granted channel
//   out_data/out_ch   registered word and the channel it came from
//   out_valid/out_ready  downstream handshake
module stream_mux_rr #(
    parameter int N = 4,
    parameter int W = 8,
    localparam int SW = ($clog2(N) > 1) ? $clog2(N) : 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode,
    input  logic [SW-1:0]   sel,
    input  logic [N*W-1:0]  in_data,
    input  logic [N-1:0]    in_valid,
    output logic [N-1:0]    in_ready,
    output logic [W-1:0]    out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [SW-1:0]   out_ch
);

    logic [W-1:0]  r_out_data;
    logic          r_out_valid;
    logic [SW-1:0] r_out_ch;
    logic [SW-1:0] r_ptr;

    logic          w_ld;
    logic          w_grant_vld;
    logic [SW-1:0] w_grant;
    logic          w_in_xfer;

    // The output register can take a new word when empty or being drained this cycle.
    assign w_ld = !r_out_valid | out_ready;

    // Grant selection. Loops run from the far end downward so that the last
    // assignment, i.e. the first match in search order, wins.
    always_comb begin
        w_grant_vld = 1'b0;
        w_grant     = '0;
        case (mode)
            2'd1: begin
                // Round-robin: search upward starting just after the last winner.
                for (int i = N; i >= 1; i--) begin
                    if (in_valid[(int'(r_ptr) + i) % N]) begin
                        w_grant_vld = 1'b1;
                        w_grant     = SW'((int'(r_ptr) + i) % N);
                    end
                end
            end
            2'd2: begin
                if (int'(sel) < N) begin
                    if (in_valid[sel]) begin
                        w_grant_vld = 1'b1;
                        w_grant     = sel;
                    end
                end
            end
            default: begin
                for (int i = N - 1; i >= 0; i--) begin
                    if (in_valid[i]) begin
                        w_grant_vld = 1'b1;
                        w_grant     = SW'(i);
                    end
                end
            end
        endcase
    end

    // in_ready depends on in_valid only through the grant, so at most one bit is set.
    always_comb begin
        in_ready = '0;
        if (!rst && w_ld && w_grant_vld) begin
            in_ready[w_grant] = 1'b1;
        end
    end

    assign w_in_xfer = !rst && w_ld && w_grant_vld;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_out_ch    <= '0;
            // Starting at N-1 makes channel 0 the first round-robin winner.
            r_ptr       <= SW'(N - 1);
        end else if (w_in_xfer) begin
            r_out_data  <= in_data[int'(w_grant) * W +: W];
            r_out_ch    <= w_grant;
            r_out_valid <= 1'b1;
            r_ptr       <= w_grant;
        end else if (r_out_valid && out_ready) begin
            // Drained with nothing new: data and channel keep their last values.
            r_out_valid <= 1'b0;
        end
    end

    assign out_data  = r_out_data;
    assign out_valid = r_out_valid;
    assign out_ch    = r_out_ch;

endmodule

// File: tb/tb_stream_mux_rr.sv
module tb_stream_mux_rr;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    // N=4, W=8 instance
    logic [1:0]  mode = 2'd0;
    logic [1:0]  sel = 2'd0;
    logic [31:0] in_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
    logic [3:0]  in_valid = 4'h0;
    logic [3:0]  in_ready;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [1:0]  out_ch;

    // N=3, W=5 instance
    logic [1:0]  m3_mode = 2'd1;
    logic [1:0]  m3_sel = 2'd0;
    logic [14:0] m3_in_data = 15'h0;
    logic [2:0]  m3_in_valid = 3'h0;
    logic [2:0]  m3_in_ready;
    logic [4:0]  m3_out_data;
    logic        m3_out_valid;
    logic        m3_out_ready = 1'b1;
    logic [1:0]  m3_out_ch;

    int n_checks = 0;
    int n_err = 0;

    logic [9:0] q4[$];
    logic [6:0] q3[$];

    int         m_ptr = 2;
    logic       m_ov = 1'b0;

    stream_mux_rr #(.N(4), .W(8)) u_dut (
        .clk(clk), .rst(rst), .mode(mode), .sel(sel),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_ch(out_ch)
    );

    stream_mux_rr #(.N(3), .W(5)) u_dut3 (
        .clk(clk), .rst(rst), .mode(m3_mode), .sel(m3_sel),
        .in_data(m3_in_data), .in_valid(m3_in_valid), .in_ready(m3_in_ready),
        .out_data(m3_out_data), .out_valid(m3_out_valid), .out_ready(m3_out_ready),
        .out_ch(m3_out_ch)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference grant for the 3-channel instance; -1 means no grant.
    function automatic int grant3(input logic [1:0] md, input logic [1:0] s,
                                  input logic [2:0] v, input int p);
        if (md == 2'd1) begin
            for (int i = 1; i <= 3; i++) begin
                if (v[(p + i) % 3]) return (p + i) % 3;
            end
            return -1;
        end else if (md == 2'd2) begin
            if (s < 2'd3 && v[s]) return int'(s);
            return -1;
        end
        for (int i = 0; i < 3; i++) begin
            if (v[i]) return i;
        end
        return -1;
    endfunction

    // Output monitor for the 4-channel instance.
    always @(negedge clk) begin
        logic [9:0] h;
        if (!rst && out_valid === 1'b1 && out_ready) begin
            if (q4.size() == 0) begin
                n_checks++;
                n_err++;
                $display("FAIL out4_unexpected: got %0h expected no word", {out_ch, out_data});
            end else begin
                h = q4.pop_front();
                check("out4_word", {22'h0, out_ch, out_data}, {22'h0, h});
            end
        end
    end

    // Model and monitor for the 3-channel instance.
    always @(negedge clk) begin
        int         g;
        logic [2:0] er;
        logic [6:0] h;
        if (rst) begin
            check("m3_rst_rdy", {29'h0, m3_in_ready}, 32'h0);
            m_ptr = 2;
            m_ov  = 1'b0;
            q3.delete();
        end else begin
            check("m3_out_valid", {31'h0, m3_out_valid}, {31'h0, m_ov});
            if (m_ov && m3_out_ready) begin
                if (q3.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL m3_unexpected: got %0h expected no word", {m3_out_ch, m3_out_data});
                end else begin
                    h = q3.pop_front();
                    check("m3_word", {25'h0, m3_out_ch, m3_out_data}, {25'h0, h});
                end
            end
            g  = grant3(m3_mode, m3_sel, m3_in_valid, m_ptr);
            er = 3'b000;
            if (g >= 0 && (!m_ov || m3_out_ready)) er[g] = 1'b1;
            check("m3_in_ready", {29'h0, m3_in_ready}, {29'h0, er});
            if (er != 3'b000) begin
                q3.push_back({2'(g), m3_in_data[g * 5 +: 5]});
                m_ptr = g;
                m_ov  = 1'b1;
            end else if (m_ov && m3_out_ready) begin
                m_ov = 1'b0;
            end
        end
    end

    initial begin
        // Reset: in_ready must stay 0 even with every channel valid.
        in_valid = 4'hF;
        repeat (2) begin
            @(negedge clk);
            check("rst_in_ready", {28'h0, in_ready}, 32'h0);
        end
        step();
        rst = 1'b0;
        in_valid = 4'h0;
        @(negedge clk);
        check("rst_out_valid", {31'h0, out_valid}, 32'h0);
        check("rst_out_data", {24'h0, out_data}, 32'h0);
        check("rst_out_ch", {30'h0, out_ch}, 32'h0);
        step();

        // Round-robin, all valid: A0 A1 A2 A3 A0 at one word per cycle.
        mode = 2'd1;
        in_valid = 4'hF;
        for (int i = 0; i < 5; i++) begin
            q4.push_back({2'(i % 4), 8'hA0 + 8'(i % 4)});
            @(negedge clk);
            check("rr_in_ready", {28'h0, in_ready}, 32'h1 << (i % 4));
            step();
        end
        in_valid = 4'h0;
        @(negedge clk);
        step();

        // Backpressure: first word from ch1, then 3 stalled cycles.
        in_valid = 4'hF;
        q4.push_back({2'd1, 8'hA1});
        step();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mode = (i == 1) ? 2'd2 : 2'd0;
            sel  = 2'd3;
            @(negedge clk);
            check("bp_in_ready", {28'h0, in_ready}, 32'h0);
            check("bp_out_data", {24'h0, out_data}, 32'hA1);
            check("bp_out_ch", {30'h0, out_ch}, 32'h1);
            check("bp_out_valid", {31'h0, out_valid}, 32'h1);
            step();
        end
        mode = 2'd1;
        out_ready = 1'b1;
        q4.push_back({2'd2, 8'hA2});
        @(negedge clk);
        check("bp_release_rdy", {28'h0, in_ready}, 32'h4);
        step();
        in_valid = 4'h0;
        @(negedge clk);
        step();
        @(negedge clk);
        check("drain_out_valid", {31'h0, out_valid}, 32'h0);
        check("drain_out_data", {24'h0, out_data}, 32'hA2);
        check("drain_out_ch", {30'h0, out_ch}, 32'h2);
        step();

        // Fixed priority: ch1 wins every cycle, ch3 starved.
        mode = 2'd0;
        in_valid = 4'b1010;
        for (int i = 0; i < 4; i++) begin
            q4.push_back({2'd1, 8'hA1});
            @(negedge clk);
            check("fp_in_ready", {28'h0, in_ready}, 32'h2);
            step();
        end
        in_valid = 4'h0;
        @(negedge clk);
        step();

        // Manual select: sel=1 with only ch2 valid gives nothing; sel=2 passes ch2.
        mode = 2'd2;
        sel = 2'd1;
        in_valid = 4'b0100;
        @(negedge clk);
        check("man_nogrant", {28'h0, in_ready}, 32'h0);
        step();
        sel = 2'd2;
        q4.push_back({2'd2, 8'hA2});
        @(negedge clk);
        check("man_grant", {28'h0, in_ready}, 32'h4);
        step();
        in_valid = 4'h0;
        @(negedge clk);
        step();

        // Mid-stream reset discards the held word; round-robin restarts at ch0.
        mode = 2'd1;
        in_valid = 4'hF;
        out_ready = 1'b0;
        step();
        rst = 1'b1;
        @(negedge clk);
        check("pre_rst_valid", {31'h0, out_valid}, 32'h1);
        check("in_rst_ready", {28'h0, in_ready}, 32'h0);
        step();
        rst = 1'b0;
        in_valid = 4'h0;
        @(negedge clk);
        check("post_rst_valid", {31'h0, out_valid}, 32'h0);
        check("post_rst_ch", {30'h0, out_ch}, 32'h0);
        step();
        out_ready = 1'b1;
        in_valid = 4'hF;
        q4.push_back({2'd0, 8'hA0});
        @(negedge clk);
        check("post_rst_rr", {28'h0, in_ready}, 32'h1);
        step();
        in_valid = 4'h0;
        @(negedge clk);
        step();
        check("q4_empty", q4.size(), 32'h0);

        // 3-channel instance: sel=3 is out of range and never grants.
        m3_mode = 2'd2;
        m3_sel = 2'd3;
        m3_in_valid = 3'b111;
        m3_in_data = {5'h13, 5'h0C, 5'h05};
        @(negedge clk);
        check("sel_oor_ready", {29'h0, m3_in_ready}, 32'h0);
        step();
        @(negedge clk);
        check("sel_oor_valid", {31'h0, m3_out_valid}, 32'h0);
        step();

        // Random traffic on the 3-channel instance, checked by the model process.
        m3_mode = 2'd1;
        for (int i = 0; i < 3000; i++) begin
            m3_in_valid  = 3'($urandom_range(0, 7));
            m3_out_ready = ($urandom_range(0, 3) != 0);
            m3_in_data   = 15'($urandom);
            m3_sel       = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 31) == 0) m3_mode = 2'($urandom_range(0, 3));
            step();
        end
        m3_in_valid = 3'h0;
        m3_out_ready = 1'b1;
        repeat (3) step();
        check("q3_empty", q3.size(), 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
